// File: rtl/bnn_pkg.sv
// Shared defaults and width helper for the binary convolution accumulator.
package bnn_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_K          = 5;
  localparam int DEF_CH         = 4;
  localparam int DEF_OUT_WIDTH  = 32;

  // Accumulator width: one sign bit on top of the data, growth for K*K
  // window terms, and growth for CH channels summed per result.
  function automatic int acc_width(input int data_width, input int k, input int ch);
    return data_width + 1 + $clog2(k * k) + $clog2(ch);
  endfunction

endpackage

// File: rtl/bconv_row_sum.sv
// One window row: K unsigned terms, each added or subtracted by its binary
// weight, summed and registered as a signed row total.
module bconv_row_sum #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 5,
  parameter int ROW_W      = DATA_WIDTH + 1 + $clog2(K)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [K*DATA_WIDTH-1:0] terms,
  input  logic [K-1:0]            wbits,
  output logic signed [ROW_W-1:0] row_sum
);

  logic signed [ROW_W-1:0] row_next;
  logic signed [ROW_W-1:0] mag;

  // Signed sum of the row, each term negated when its weight bit is 0.
  always_comb begin
    row_next = '0;
    mag      = '0;
    for (int i = 0; i < K; i++) begin
      mag      = ROW_W'({1'b0, terms[i*DATA_WIDTH +: DATA_WIDTH]});
      row_next = row_next + (wbits[i] ? mag : -mag);
    end
  end

  // Row total register, advancing with the rest of the pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      row_sum <= '0;
    else if (en)
      row_sum <= row_next;
  end

endmodule

// File: rtl/bconv_kxk_acc.sv
// KxK binary-weight convolution with per-channel accumulation.
// Four stages: capture, row sums, window sum, accumulate/output.
module bconv_kxk_acc
  import bnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int CH         = DEF_CH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sclr,
  input  logic                      ivalid,
  output logic                      iready,
  input  logic [K*K*DATA_WIDTH-1:0] idata,
  input  logic [K*K-1:0]            weight,
  input  logic [OUT_WIDTH-1:0]      bias,
  output logic                      ovalid,
  input  logic                      oready,
  output logic [OUT_WIDTH-1:0]      dout,
  output logic                      obin
);

  localparam int ACC_W = acc_width(DATA_WIDTH, K, CH);
  localparam int ROW_W = DATA_WIDTH + 1 + $clog2(K);
  localparam int WIN_W = DATA_WIDTH + 1 + $clog2(K * K);
  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1;

  logic                      en;
  logic                      accept;
  logic [CNT_W-1:0]          count;
  logic                      is_first;
  logic                      is_last;

  logic                      s1_valid, s1_first, s1_last;
  logic [K*K*DATA_WIDTH-1:0] s1_data;
  logic [K*K-1:0]            s1_weight;
  logic signed [ACC_W-1:0]   s1_bias;

  logic                      s2_valid, s2_first, s2_last;
  logic signed [ACC_W-1:0]   s2_bias;
  logic signed [ROW_W-1:0]   row_sum [K];

  logic                      s3_valid, s3_first, s3_last;
  logic signed [ACC_W-1:0]   s3_bias;
  logic signed [WIN_W-1:0]   s3_win;
  logic signed [WIN_W-1:0]   win_next;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;

  assign en       = ~ovalid | oready;
  assign iready   = en & ~sclr;
  assign accept   = ivalid & iready;
  assign is_first = (count == '0);
  assign is_last  = (count == CNT_W'(CH - 1));

  // Bias bits above the accumulator width never influence the result.
  if (OUT_WIDTH > ACC_W) begin : g_bias_hi
    logic unused_bias_hi;
    assign unused_bias_hi = ^bias[OUT_WIDTH-1:ACC_W];
  end

  // Channel position within the current group; cleared by sclr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      count <= '0;
    else if (sclr)
      count <= '0;
    else if (accept)
      count <= is_last ? '0 : count + CNT_W'(1);
  end

  // S1: capture the accepted window, weights, bias and group tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      s1_weight <= '0;
      s1_bias   <= '0;
    end else begin
      if (sclr)
        s1_valid <= 1'b0;
      else if (en)
        s1_valid <= accept;
      if (accept) begin
        s1_first  <= is_first;
        s1_last   <= is_last;
        s1_data   <= idata;
        s1_weight <= weight;
        s1_bias   <= bias[ACC_W-1:0];
      end
    end
  end

  // S2: one registered row sum per window row.
  for (genvar r = 0; r < K; r++) begin : g_row
    bconv_row_sum #(
      .DATA_WIDTH (DATA_WIDTH),
      .K          (K),
      .ROW_W      (ROW_W)
    ) u_row (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .terms   (s1_data[r*K*DATA_WIDTH +: K*DATA_WIDTH]),
      .wbits   (s1_weight[r*K +: K]),
      .row_sum (row_sum[r])
    );
  end

  // S2: carry the tags and bias alongside the row sums.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
    end else begin
      if (sclr)
        s2_valid <= 1'b0;
      else if (en)
        s2_valid <= s1_valid;
      if (en) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_bias  <= s1_bias;
      end
    end
  end

  // Combine the K signed row sums into the window total.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < K; r++)
      win_next = win_next + WIN_W'(row_sum[r]);
  end

  // S3: register the window total with its tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
      s3_bias  <= '0;
      s3_win   <= '0;
    end else begin
      if (sclr)
        s3_valid <= 1'b0;
      else if (en)
        s3_valid <= s2_valid;
      if (en) begin
        s3_first <= s2_first;
        s3_last  <= s2_last;
        s3_bias  <= s2_bias;
        s3_win   <= win_next;
      end
    end
  end

  // First beat of a group restarts from the bias, others extend the sum.
  always_comb begin
    acc_base = s3_first ? s3_bias : acc;
    acc_next = acc_base + ACC_W'(s3_win);
  end

  // S4: accumulate, publish the finished group, and drop ovalid once taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      ovalid <= 1'b0;
      dout   <= '0;
      obin   <= 1'b0;
    end else begin
      if (en)
        ovalid <= s3_valid & s3_last & ~sclr;
      if (sclr) begin
        acc <= '0;
      end else if (en && s3_valid) begin
        acc <= acc_next;
        if (s3_last) begin
          dout <= OUT_WIDTH'(acc_next);
          obin <= ~acc_next[ACC_W-1];
        end
      end
    end
  end

endmodule

// File: doc/bconv_kxk_acc.md
BCONV_KXK_ACC -- requirements
Module: bconv_kxk_acc

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 8, unsigned activation width.
- K, 5, window side; K*K terms per beat.
- CH, 4, input channels accumulated per output; CH >= 1.
- OUT_WIDTH, 32, dout width; OUT_WIDTH >= ACC_W.
REQ-002 Derived: ACC_W = DATA_WIDTH + 1 + clog2(K*K) + clog2(CH).
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- sclr, in, 1, synchronous clear.
- ivalid, in, 1, input beat valid.
- iready, out, 1, input beat accepted when ivalid & iready.
- idata, in, K*K*DATA_WIDTH, window; term i at bits [i*DATA_WIDTH +: DATA_WIDTH], row-major, top-left = 0.
- weight, in, K*K, binary weights; bit i applies to term i.
- bias, in, OUT_WIDTH, signed; sampled with the first beat of each group.
- ovalid, out, 1, result valid.
- oready, in, 1, result taken when ovalid & oready.
- dout, out, OUT_WIDTH, signed result, sign-extended from ACC_W.
- obin, out, 1, binarised result; 1 when dout >= 0.

Function
REQ-004 Term rule: weight bit 1 gives +data; bit 0 gives -data. Each term is signed, DATA_WIDTH+1 bits, with exact two's-complement negation.
REQ-005 Pipeline of 4 registered stages, all advancing only when en = ~ovalid | oready:
- S1: capture idata, weight, first and last tags.
- S2: K signed row sums.
- S3: window sum.
- S4: accumulator and output.
REQ-006 iready SHALL equal en & ~sclr.
REQ-007 Channel counter:
- Range 0..CH-1; increments on each accepted beat; wraps to 0 after CH-1.
- first = (count == 0); last = (count == CH-1); with CH = 1 every beat is both.
REQ-008 Accumulator at S4:
- first beat: acc = bias + window.
- other beats: acc = acc + window.
- All arithmetic exact at ACC_W bits; no saturation.
REQ-009 On a last beat at S4: dout <= acc result (sign-extended), obin <= ~sign, ovalid <= 1.
REQ-010 When ovalid & oready with no new result arriving, ovalid <= 0; dout and obin hold their values.
REQ-011 Latency: the last beat accepted at edge N gives ovalid high from edge N+3; throughput is one beat per cycle while oready = 1.
REQ-012 Back-pressure: while ovalid & ~oready, all stages, the counter and the accumulator freeze, and dout holds.
REQ-013 sclr (sampled on the edge):
- counter -> 0; S1..S3 valid flags -> 0; accumulator -> 0.
- ovalid, dout and obin are unaffected.
- Any partial group is discarded.
REQ-014 sclr together with ivalid: sclr wins, no beat is accepted, and the counter reads 0 afterwards.
REQ-015 Bubbles (ivalid low) SHALL NOT advance the counter or alter the accumulator.

Reset
REQ-016 rstn low, asynchronously:
- ovalid = 0, dout = 0, obin = 0.
- counter = 0; all stage valids = 0; accumulator = 0; all pipeline data registers = 0.
REQ-017 Reset asserted mid-group discards the group; the first accepted beat after release is a first beat.
REQ-018 iready SHALL be 1 in the first cycle after reset release, unless sclr is high.

Structure
REQ-019 Package bnn_pkg SHALL hold the default DATA_WIDTH/K/CH/OUT_WIDTH constants and the ACC_W width function.
REQ-020 Sub-module bconv_row_sum (K terms plus K weight bits in, registered signed row sum out, with enable) SHALL be instantiated K times for S2.
REQ-021 No multipliers; terms are formed by conditional negation only.

Verification
REQ-022 Defaults (DATA_WIDTH=8, K=5, CH=4, OUT_WIDTH=32). Directed scenarios:
- Data all 1, weights all 1, bias 0, 4 beats back-to-back -> dout = 100, obin = 1, ovalid 3 edges after the 4th accept.
- Data all 255, weights all 0, bias 0, 4 beats -> dout = -25500 (0xFFFF9C64), obin = 0.
- Bias -10; beat 1 data all 2 with weights all 1, beats 2-4 data 0 -> dout = 40; then bias 0x7FFF_FFF0 is not checked for overflow, as OUT_WIDTH exceeds ACC_W.
- oready low 6 cycles during 3 back-to-back groups -> iready drops, dout held constant, all 3 results delivered in order with no loss or duplication.
- 2 beats, then sclr coinciding with ivalid, then 4 beats of data all 1 with weights all 1 -> single result 100.
- rstn pulsed after 3 beats -> outputs 0 immediately; next 4-beat group yields the correct fresh sum.
